// File: rtl/strided_reader_if.sv
// Strided reader bus: request, memory read port and output stream.
// Latency: none, signal bundle only.
// Backpressure: out_ready from the consumer, carried to the reader.
interface strided_reader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) ();
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] stride;
    logic [LEN_WIDTH-1:0]  length;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;

    // The reader side.
    modport master (
        input  start, base_addr, stride, length, mem_rd_data, out_ready,
        output mem_rd_en, mem_addr, out_data, out_valid, busy, done
    );

    // The requester / memory / consumer side.
    modport slave (
        output start, base_addr, stride, length, mem_rd_data, out_ready,
        input  mem_rd_en, mem_addr, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/strided_reader.sv
// Strided memory reader: issues base + k*stride reads and streams the words out.
// Latency: first out_valid 2 cycles after busy rises; one word per cycle sustained.
// Backpressure: out_ready low stalls reads once 2 words are buffered or in flight.
module strided_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    strided_reader_if.master  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_READ   = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [LEN_WIDTH-1:0]  rem_cnt;
    logic                  rd_pending;

    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_cnt;

    logic                  fifo_wr;
    logic                  fifo_rd;
    logic                  rd_issue;
    logic [1:0]            committed;

    assign fifo_rd = (fifo_cnt != 2'd0) && bus.out_ready;
    assign fifo_wr = rd_pending;

    // Slots spoken for after this cycle: words that stay buffered plus the word landing now.
    // Counting the departing word lets a free-flowing consumer see one read per cycle.
    assign committed = fifo_cnt - {1'b0, fifo_rd} + {1'b0, rd_pending};
    assign rd_issue  = (state == ST_READ) && (committed < 2'd2);

    assign bus.mem_rd_en = rd_issue;
    assign bus.mem_addr  = cur_addr;
    assign bus.out_valid = (fifo_cnt != 2'd0);
    assign bus.out_data  = fifo_mem[rd_ptr];
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_FINISH);

    // Control FSM: latch the request, walk the address sequence, wait for drain, pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cur_addr <= '0;
            stride_q <= '0;
            rem_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        cur_addr <= bus.base_addr;
                        stride_q <= bus.stride;
                        rem_cnt  <= bus.length;
                        state    <= (bus.length == '0) ? ST_FINISH : ST_READ;
                    end
                end
                ST_READ: begin
                    if (rd_issue) begin
                        // Carry out of the address add is dropped: addresses wrap.
                        cur_addr <= cur_addr + stride_q;
                        rem_cnt  <= rem_cnt - LEN_WIDTH'(1);
                        if (rem_cnt == LEN_WIDTH'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((fifo_cnt == 2'd0) && !rd_pending) begin
                        state <= ST_FINISH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Tracks the read whose data arrives from memory on the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= rd_issue;
        end
    end

    // Two-entry output FIFO; simultaneous push and pop keep the occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (fifo_wr) begin
                fifo_mem[wr_ptr] <= bus.mem_rd_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (fifo_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, fifo_wr} - {1'b0, fifo_rd};
        end
    end
endmodule

// File: tb/tb_strided_reader.sv
// Testbench for strided_reader: random memory image, scoreboard of expected
// addresses and words built from base + k*stride (mod 2^ADDR_WIDTH), with a
// negedge monitor that pops and compares whenever the DUT reads or delivers.
module tb_strided_reader;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    strided_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    strided_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] mem_array [1 << AW];
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_data [$];

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int busy_rise = 0;
    int first_valid = -1;
    int first_rd = -1;
    int last_rd = -1;
    logic busy_q = 1'b0;
    logic stall_q = 1'b0;
    logic [DW-1:0] held = '0;
    logic rand_en = 1'b0;
    logic ready_force = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem_array[bus.mem_addr];
    end

    // Consumer ready: random or forced by the stimulus.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Monitor: compares every issued address and every delivered word against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            busy_q  = 1'b0;
            stall_q = 1'b0;
        end else begin
            if (bus.busy && !busy_q) begin
                busy_rise   = cyc;
                first_valid = -1;
                first_rd    = -1;
            end
            busy_q = bus.busy;
            if (bus.mem_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                if (exp_addr.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_read: got addr 0x%0h, want no read", bus.mem_addr);
                end else begin
                    check("mem_addr", 64'(bus.mem_addr), 64'(exp_addr.pop_front()));
                end
            end
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (stall_q && bus.out_valid) check("out_data_hold", 64'(bus.out_data), 64'(held));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_data.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, want no word", bus.out_data);
                end else begin
                    check("out_data", 64'(bus.out_data), 64'(exp_data.pop_front()));
                end
            end
            stall_q = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
            if (bus.done) done_cnt++;
        end
    end

    // Reference model: the k-th read is at (base + k*stride) mod 2^AW.
    task automatic expect_xfer(input int b, input int s, input int l);
        logic [AW-1:0] a;
        for (int k = 0; k < l; k++) begin
            a = AW'((b + k * s) % (1 << AW));
            exp_addr.push_back(a);
            exp_data.push_back(mem_array[a]);
        end
    endtask

    task automatic pulse_start(input int b, input int s, input int l);
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = AW'(b);
        bus.stride    = AW'(s);
        bus.length    = LW'(l);
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.base_addr = AW'($urandom);
        bus.stride    = AW'($urandom);
        bus.length    = LW'($urandom);
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != d0) break;
        end
        if (done_cnt == d0) begin
            n_vec++;
            n_fail++;
            $display("FAIL done_timeout: got no done in %0d cycles, want a done pulse", budget);
        end
    endtask

    task automatic finish_checks(input int d0);
        #2;
        check("addr_queue_empty", 64'(exp_addr.size()), 64'd0);
        check("data_queue_empty", 64'(exp_data.size()), 64'd0);
        repeat (3) @(posedge clk);
        #2;
        check("done_once", 64'(done_cnt - d0), 64'd1);
        check("busy_idle", 64'(bus.busy), 64'd0);
    endtask

    task automatic run_xfer(input int b, input int s, input int l);
        int d0;
        d0 = done_cnt;
        expect_xfer(b, s, l);
        pulse_start(b, s, l);
        wait_done(d0, l * 10 + 60);
        finish_checks(d0);
    endtask

    initial begin
        int d0;
        int r0;
        #1200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int r0;
        bus.start       = 1'b0;
        bus.base_addr   = '0;
        bus.stride      = '0;
        bus.length      = '0;
        bus.mem_rd_data = '0;
        for (int i = 0; i < (1 << AW); i++) mem_array[i] = DW'($urandom);

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", 64'({bus.mem_rd_en, bus.mem_addr, bus.out_valid,
                                    bus.out_data, bus.busy, bus.done}), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic run, free-flowing consumer: consecutive addresses, 2-cycle latency.
        run_xfer(8'h10, 4, 4);
        check("first_valid_latency", 64'(first_valid - busy_rise), 64'd2);
        check("read_span", 64'(last_rd - first_rd), 64'd3);

        // Address wrap.
        r0 = rd_cnt;
        run_xfer(8'hF8, 8'h08, 3);
        check("wrap_reads", 64'(rd_cnt - r0), 64'd3);

        // Zero length: one busy cycle with done, no reads.
        r0 = rd_cnt;
        d0 = done_cnt;
        pulse_start(8'h33, 1, 0);
        @(negedge clk);
        #1;
        check("len0_busy_done", 64'({bus.busy, bus.done}), 64'b11);
        @(negedge clk);
        #1;
        check("len0_after", 64'({bus.busy, bus.done}), 64'b00);
        check("len0_no_reads", 64'(rd_cnt - r0), 64'd0);
        check("len0_done_once", 64'(done_cnt - d0), 64'd1);

        // Consumer stalled for 10 cycles: only two reads may be issued, head held.
        ready_force = 1'b0;
        @(posedge clk);
        r0 = rd_cnt;
        d0 = done_cnt;
        expect_xfer(8'h5A, 8'h21, 5);
        pulse_start(8'h5A, 8'h21, 5);
        repeat (10) @(posedge clk);
        #2;
        check("stall_reads", 64'(rd_cnt - r0), 64'd2);
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        ready_force = 1'b1;
        wait_done(d0, 120);
        finish_checks(d0);

        // Second start while busy is ignored.
        r0 = rd_cnt;
        d0 = done_cnt;
        expect_xfer(8'h40, 3, 6);
        pulse_start(8'h40, 3, 6);
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = 8'h90;
        bus.stride    = 8'h07;
        bus.length    = 8'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(d0, 120);
        finish_checks(d0);
        check("ignored_start_reads", 64'(rd_cnt - r0), 64'd6);

        // Reset during the third read: everything clears, no done.
        r0 = rd_cnt;
        d0 = done_cnt;
        expect_xfer(8'h80, 5, 8);
        pulse_start(8'h80, 5, 8);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (rd_cnt >= r0 + 3) break;
        end
        check("reads_before_reset", 64'(rd_cnt - r0), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("reset_mid_outputs", 64'({bus.mem_rd_en, bus.mem_addr, bus.out_valid,
                                        bus.out_data, bus.busy, bus.done}), 64'd0);
        check("reset_no_done", 64'(done_cnt - d0), 64'd0);
        @(posedge clk);
        #1;
        exp_addr.delete();
        exp_data.delete();
        reset = 1'b0;
        run_xfer(8'h22, 8'h11, 5);

        // Random transfers with a random consumer, then a maximum-length one.
        rand_en = 1'b1;
        for (int t = 0; t < 6; t++) begin
            run_xfer(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(1, 24)));
        end
        run_xfer(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), (1 << LW) - 1);
        rand_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/strided_reader.md
STRIDED_READER -- requirements
Module: strided_reader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, the width of memory addresses.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, the width of memory read data.
REQ-003 The block SHALL have parameter LEN_WIDTH, default 8, the width of the transfer length.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, a one-cycle request to begin a transfer.
REQ-007 The block SHALL have port base_addr, input, ADDR_WIDTH, the first read address, sampled on an accepted start.
REQ-008 The block SHALL have port stride, input, ADDR_WIDTH, the address increment, sampled on an accepted start.
REQ-009 The block SHALL have port length, input, LEN_WIDTH, the number of words to read, sampled on an accepted start.
REQ-010 The block SHALL have port mem_rd_en, output, 1, the memory read strobe.
REQ-011 The block SHALL have port mem_addr, output, ADDR_WIDTH, the memory read address.
REQ-012 The block SHALL have port mem_rd_data, input, DATA_WIDTH, memory data, valid exactly 1 cycle after mem_rd_en.
REQ-013 The block SHALL have port out_data, output, DATA_WIDTH, the stream data.
REQ-014 The block SHALL have port out_valid, output, 1, high when out_data holds a word.
REQ-015 The block SHALL have port out_ready, input, 1, the consumer accept signal.
REQ-016 The block SHALL have port busy, output, 1, high from an accepted start until done.
REQ-017 The block SHALL have port done, output, 1, a one-cycle pulse at transfer completion.

Function
REQ-018 The block SHALL implement the states IDLE, READ, DRAIN and FINISH.
REQ-019 In IDLE, a start SHALL latch base_addr, stride and length, and move the block to READ; if length is 0, it SHALL move to FINISH instead.
REQ-020 A start SHALL be ignored while busy is high.
REQ-021 In READ, mem_rd_en SHALL assert only when (buffered words + reads in flight) < 2; mem_addr SHALL equal base_addr + k*stride for the k-th read (k from 0).
REQ-022 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; any carry out SHALL be discarded, so the address wraps silently.
REQ-023 Returned data SHALL enter a 2-entry FIFO on the cycle after mem_rd_en; the FIFO SHALL never overflow.
REQ-024 out_valid SHALL be high whenever the FIFO is non-empty; out_data SHALL be the FIFO head.
REQ-025 A word SHALL transfer when out_valid and out_ready are both high; out_data SHALL be held stable while out_valid is high and out_ready is low.
REQ-026 A FIFO write and a FIFO read in the same cycle SHALL leave the occupancy unchanged.
REQ-027 After length reads have been issued, the block SHALL move to DRAIN; from DRAIN it SHALL move to FINISH once the FIFO is empty and no read is in flight.
REQ-028 FINISH SHALL last one cycle, during which done=1; busy SHALL then drop to 0 and the block SHALL return to IDLE.
REQ-029 busy SHALL be high in READ, DRAIN and FINISH.
REQ-030 When out_ready is held high, the block SHALL sustain one word per cycle, with the first out_valid 2 cycles after start.
REQ-031 length SHALL be treated as unsigned; a length of 2^LEN_WIDTH-1 SHALL be supported.

Reset
REQ-032 While reset=1, the block SHALL be in IDLE with the FIFO empty, no read in flight, and mem_rd_en, mem_addr, out_valid, out_data, busy and done all 0.
REQ-033 A reset asserted mid-transfer SHALL abort the transfer immediately, with no done pulse; data in flight SHALL be discarded.
REQ-034 After reset deasserts, the first start SHALL be accepted normally.

Verification
REQ-035 The bench SHALL cover: base=0x10, stride=4, length=4, out_ready=1 -> mem_addr 0x10, 0x14, 0x18, 0x1C on consecutive cycles; 4 words out in order; done pulses once.
REQ-036 The bench SHALL cover: base=0xF8, stride=0x08, length=3 -> addresses 0xF8, 0x00, 0x08 (wrap).
REQ-037 The bench SHALL cover: length=0 -> no mem_rd_en; busy high for 1 cycle with done=1.
REQ-038 The bench SHALL cover: out_ready=0 for 10 cycles, length=5 -> at most 2 reads issued; out_data stable; all 5 words delivered in order after out_ready=1.
REQ-039 The bench SHALL cover: a second start while busy -> ignored; addresses are unchanged from the first transfer.
REQ-040 The bench SHALL cover: reset at the 3rd read -> all outputs 0 next cycle; no done pulse; a new start then runs cleanly.
